// File: rtl/uart_tx_merge.sv
// Merges byte writes from two harts into one ordered UART transmit stream.
// First-word fall-through FIFO; hart A's byte always precedes hart B's in a cycle.
module uart_tx_merge #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [7:0]    a_data,
    input  logic          b_valid,
    input  logic [7:0]    b_data,
    output logic          a_busy,
    output logic          b_busy,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_b;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free;
    logic          overflow_q;
    logic          acc_a;
    logic          acc_b;
    logic          pop;

    // Acceptance uses this cycle's free space only; a same-cycle pop never makes room.
    always_comb begin
        free     = CW'(DEPTH) - count_q;
        acc_a    = a_valid && (free >= CW'(1));
        acc_b    = b_valid && (free >= (acc_a ? CW'(2) : CW'(1)));
        pop      = tx_valid && tx_ready;
        wr_ptr_b = wr_ptr + AW'(acc_a);
    end

    assign tx_valid = (count_q != '0);
    assign tx_data  = mem[rd_ptr];
    assign a_busy   = (free < CW'(2));
    assign b_busy   = a_busy;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(acc_a) + AW'(acc_b);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop);
            if ((a_valid && !acc_a) || (b_valid && !acc_b)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (acc_a) begin
            mem[wr_ptr] <= a_data;
        end
        if (acc_b) begin
            mem[wr_ptr_b] <= b_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_merge.sv
// Directed bench for uart_tx_merge with a small queue model for the streaming section.
module tb_uart_tx_merge;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid;
    logic [7:0]    a_data;
    logic          b_valid;
    logic [7:0]    b_data;
    logic          a_busy;
    logic          b_busy;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW:0]   count;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];
    logic       ovf_exp = 1'b0;

    uart_tx_merge #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .a_busy   (a_busy),
        .b_busy   (b_busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_valid  = 1'b0;
        a_data   = 8'h00;
        b_valid  = 1'b0;
        b_data   = 8'h00;
        tx_ready = 1'b0;
    endtask

    // Advance one edge and leave the bench 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
    endtask

    // One model-checked cycle: predicts acceptance, pop and resulting state.
    task automatic cyc(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic rdy);
        int   fr;
        logic aa;
        logic ab;
        logic pp;
        fr = int'(DEPTH) - q.size();
        aa = av && (fr >= 1);
        ab = bv && (fr >= (aa ? 2 : 1));
        pp = rdy && (q.size() != 0);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; tx_ready = rdy;
        if (pp) begin
            chk("cyc_head", 32'(tx_data), 32'(q[0]));
            void'(q.pop_front());
        end
        if (aa) q.push_back(ad);
        if (ab) q.push_back(bd);
        if ((av && !aa) || (bv && !ab)) ovf_exp = 1'b1;
        step();
        idle();
        chk("cyc_count", 32'(count), 32'(q.size()));
        chk("cyc_valid", 32'(tx_valid), 32'(q.size() != 0));
        chk("cyc_ovf", 32'(overflow), 32'(ovf_exp));
        if (q.size() != 0) chk("cyc_data", 32'(tx_data), 32'(q[0]));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(tx_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_busy", 32'({a_busy, b_busy}), 32'(0));
        reset = 1'b0;

        // Single push then pop
        a_valid = 1'b1; a_data = 8'h41;
        step(); idle();
        chk("single_valid", 32'(tx_valid), 32'(1));
        chk("single_data", 32'(tx_data), 32'(8'h41));
        chk("single_count", 32'(count), 32'(1));
        tx_ready = 1'b1;
        step(); idle();
        chk("single_pop_count", 32'(count), 32'(0));
        chk("single_pop_valid", 32'(tx_valid), 32'(0));

        // Simultaneous push: A before B
        a_valid = 1'b1; a_data = 8'h48; b_valid = 1'b1; b_data = 8'h69;
        step(); idle();
        chk("sim_count", 32'(count), 32'(2));
        chk("sim_first", 32'(tx_data), 32'(8'h48));
        tx_ready = 1'b1;
        step();
        chk("sim_second", 32'(tx_data), 32'(8'h69));
        chk("sim_count1", 32'(count), 32'(1));
        step(); idle();
        chk("sim_empty", 32'(count), 32'(0));
        chk("sim_ovf", 32'(overflow), 32'(0));

        // Fill to full, then one dropped push
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_data = 8'(i);
            step(); idle();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_busy", 32'({a_busy, b_busy}), (i + 1 >= 15) ? 32'(3) : 32'(0));
        end
        a_valid = 1'b1; a_data = 8'hEE;
        step(); idle();
        chk("full_ovf", 32'(overflow), 32'(1));
        chk("full_count", 32'(count), 32'(16));
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(tx_data), 32'(i));
            tx_ready = 1'b1;
            step(); idle();
        end
        chk("drain_empty", 32'(tx_valid), 32'(0));
        chk("drain_ovf_sticky", 32'(overflow), 32'(1));

        // Partial-space race: only A fits
        do_reset();
        chk("race_rst_ovf", 32'(overflow), 32'(0));
        for (int i = 0; i < 15; i++) begin
            a_valid = 1'b1; a_data = 8'(8'h30 + i);
            step(); idle();
        end
        chk("race_pre_count", 32'(count), 32'(15));
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22;
        step(); idle();
        chk("race_count", 32'(count), 32'(16));
        chk("race_ovf", 32'(overflow), 32'(1));
        tx_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("race_last", 32'(tx_data), 32'(8'h11));
        step(); idle();
        chk("race_empty", 32'(count), 32'(0));

        // Streaming with wrap; pops and pushes interleave
        do_reset();
        for (int k = 0; k < 80; k++) begin
            cyc((k % 4) == 0, 8'(8'h80 + k), (k % 4) == 2, 8'(8'hC0 + k), (k % 4) >= 2);
        end
        while (q.size() != 0) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        // 40 pushes put wr_ptr at 8; seven more reach 15 for a wrapping double push
        for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        while (q.size() != 0) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Async reset between edges
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0, 8'h00, 1'b0);
        chk("areset_pre", 32'(count), 32'(5));
        #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(tx_valid), 32'(0));
        chk("areset_count", 32'(count), 32'(0));
        chk("areset_ovf", 32'(overflow), 32'(0));
        reset = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
        step();
        a_valid = 1'b1; a_data = 8'h55;
        step(); idle();
        chk("areset_first", 32'(tx_data), 32'(8'h55));
        chk("areset_cnt1", 32'(count), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
